serial_frame_rx: RTL

Receive end of the inter-board serial column link. Listens on a slow forwarded clock line (`clk_in`) and data line (`bit_in`) driven by the partner board's serial transmitter, and synchronizes both into the local `clk` domain. It deframes and parity-checks a 7-bit column word and presents it on a hold register with a one-cycle valid strobe. It drives the `ready_out` GPIO back to the transmitter to pace frames.

---
 rtl/serial_frame_rx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receive end of the inter-board serial column link.
// Synchronizes the forwarded clock and data lines into clk, deframes a
// start bit + WIDTH data bits (LSB first) + even parity bit, and presents
// good words on a hold register with a one-cycle valid strobe.
module serial_frame_rx #(
    parameter int WIDTH   = 7,
    parameter int TIMEOUT = 1024,
    parameter int HOLDOFF = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             bit_in,
    output logic [WIDTH-1:0] column,
    output logic             column_valid,
    output logic             parity_err,
    output logic             timeout_err,
    output logic             ready_out
);

    localparam int CNT_W = ($clog2(WIDTH + 2) > 0) ? $clog2(WIDTH + 2) : 1;
    localparam int TMO_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam int HLD_W = ($clog2(HOLDOFF) > 0) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    logic             clk_s1_q, clk_s2_q, clk_s3_q;
    logic             bit_s1_q, bit_s2_q;
    logic             rise;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [HLD_W-1:0] hld_q, hld_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] column_q, column_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             terr_q, terr_d;
    logic             ready_q, ready_d;

    assign rise = clk_s2_q & ~clk_s3_q;

    // Next-state and registered-output logic for the deframing FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        hld_d    = hld_q;
        sh_d     = sh_q;
        column_d = column_q;
        valid_d  = 1'b0;
        perr_d   = 1'b0;
        terr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise && bit_s2_q) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    sh_d    = '0;
                end
            end
            SHIFT: begin
                if (rise) begin
                    tmo_d = '0;
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        // Counter == WIDTH means this rise carries the parity bit.
                        if (^{sh_q, bit_s2_q}) begin
                            perr_d = 1'b1;
                        end else begin
                            column_d = sh_q;
                            valid_d  = 1'b1;
                        end
                        state_d = HOLD;
                        hld_d   = '0;
                    end else begin
                        for (int unsigned i = 0; i < WIDTH; i++) begin
                            if (cnt_q == CNT_W'(i)) sh_d[i] = bit_s2_q;
                        end
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = HOLD;
                    hld_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            HOLD: begin
                if (hld_q == HLD_W'(HOLDOFF - 1)) begin
                    state_d = IDLE;
                end else begin
                    hld_d = hld_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d != HOLD);
    end

    // Synchronizers, edge-detect delay, FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q <= 1'b0;
            clk_s2_q <= 1'b0;
            clk_s3_q <= 1'b0;
            bit_s1_q <= 1'b0;
            bit_s2_q <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            tmo_q    <= '0;
            hld_q    <= '0;
            sh_q     <= '0;
            column_q <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            terr_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            clk_s1_q <= clk_in;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            bit_s1_q <= bit_in;
            bit_s2_q <= bit_s1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            hld_q    <= hld_d;
            sh_q     <= sh_d;
            column_q <= column_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            terr_q   <= terr_d;
            ready_q  <= ready_d;
        end
    end

    assign column       = column_q;
    assign column_valid = valid_q;
    assign parity_err   = perr_q;
    assign timeout_err  = terr_q;
    assign ready_out    = ready_q;

endmodule
